// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio stream controller.
package audio_ctrl_pkg;

  localparam int PCM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    PLAY  = 2'd2
  } asc_state_t;

endpackage

// File: rtl/asc_fifo.sv
// Single-clock show-ahead sample FIFO with occupancy level and synchronous flush.
module asc_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Audio stream controller: FIFO priming, sample-rate divider and volume shift.
// Optional AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN adds a saturating underrun counter.
module audio_stream_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            sample_div,
  input  logic [1:0]                  vol_shift,
  input  logic                        s_valid,
  input  logic [15:0]                 s_data,
  output logic                        s_ready,
  output logic [15:0]                 pcm_out,
  output logic                        pcm_strobe,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        playing,
  output logic [1:0]                  state_dbg
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] HALF_LVL = LW'(FIFO_DEPTH / 2);

  asc_state_t              state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [PCM_W-1:0]        pcm_q, pcm_d;
  logic                    strobe_q, strobe_d;
  logic                    underrun_q, underrun_d;
  logic                    tick;
  logic                    fifo_full, fifo_empty;
  logic [PCM_W-1:0]        fifo_rd_data;
  logic signed [PCM_W-1:0] shifted;

  // Handshake: a sample moves on every cycle where s_valid && s_ready; s_ready is low during reset.
  assign s_ready = !fifo_full && enable && !rst;
  assign tick    = (state_q == PLAY) && enable && (div_q == sample_div);
  assign shifted = $signed(fifo_rd_data) >>> vol_shift;

  asc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PCM_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (!enable),
    .push    (s_valid && s_ready),
    .pop     (tick && !fifo_empty),
    .wr_data (s_data),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (fifo_level >= HALF_LVL) state_d = PLAY;
        PLAY:    if (tick && fifo_empty) state_d = PRIME;
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider only counts in PLAY; a tick restarts it and drives the output stage.
  always_comb begin
    div_d      = '0;
    pcm_d      = pcm_q;
    strobe_d   = 1'b0;
    underrun_d = 1'b0;
    if (!enable) begin
      pcm_d = '0;
    end else if (state_q == PLAY) begin
      if (tick) begin
        strobe_d = 1'b1;
        if (fifo_empty) begin
          pcm_d      = '0;
          underrun_d = 1'b1;
        end else begin
          pcm_d = shifted;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      pcm_q      <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      pcm_q      <= pcm_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign pcm_out    = pcm_q;
  assign pcm_strobe = strobe_q;
  assign underrun   = underrun_q;
  assign playing    = (state_q == PLAY);
  assign state_dbg  = state_q;

`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Counts alongside the pulse; only rst clears it, a stop/flush does not.
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: volume-shift vector table plus prime/play/underrun,
// backpressure, stop-flush and asynchronous-reset sequences.
module tb_audio_stream_ctrl;
  import audio_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready, pcm_strobe, underrun, playing;
  logic [15:0] sample_div, s_data, pcm_out;
  logic [1:0]  vol_shift, state_dbg;
  logic [3:0]  fifo_level;
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int          total = 0;
  int          bad   = 0;
  int          guard;
  bit          seen;
  logic        sb_on = 1'b0;
  logic [15:0] exp_v;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic [1:0]  sh;
    logic [15:0] want;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  audio_stream_ctrl #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_div   (sample_div),
    .vol_shift    (vol_shift),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .pcm_out      (pcm_out),
    .pcm_strobe   (pcm_strobe),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .playing      (playing),
    .state_dbg    (state_dbg)
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepted samples, match each non-underrun strobe in order.
  always @(negedge clk) begin
    if (sb_on) begin
      if (pcm_strobe && !underrun) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra actual=%h required=no_sample", pcm_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (pcm_out !== exp_v) begin
            bad++;
            $display("FAIL sb_data actual=%h required=%h", pcm_out, exp_v);
          end
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h8000, 2'd2, 16'hE000};
    vecs[1] = '{16'h7FFF, 2'd3, 16'h0FFF};
    vecs[2] = '{16'h1234, 2'd0, 16'h1234};
    vecs[3] = '{16'hFFFF, 2'd3, 16'hFFFF};
    vecs[4] = '{16'h0010, 2'd1, 16'h0008};
    vecs[5] = '{16'h8001, 2'd1, 16'hC000};
    vecs[6] = '{16'h4000, 2'd3, 16'h0800};
    vecs[7] = '{16'hF000, 2'd2, 16'hFC00};

    rst = 1'b1; enable = 1'b1; s_valid = 1'b0; s_data = '0;
    sample_div = 16'd3; vol_shift = 2'd0;

    // Reset values, including s_ready held low although enable is high.
    #2;
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_strobe", pcm_strobe, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk1("rst_playing", playing, 1'b0);
    chk("rst_pcm", pcm_out, 16'h0000);
    chk("rst_level", 16'(fifo_level), 16'd0);
    step();
    step();
    chk("rst_state", 16'(state_dbg), 16'(IDLE));
    chk1("rst_s_ready_clk", s_ready, 1'b0);
    enable = 1'b0;
    rst = 1'b0;

    // Prime with 4 samples, play at sample_div=3, then underrun.
    enable = 1'b1; s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_data = 16'(16'h0101 * i);
      exp_q.push_back(s_data);
      step();
    end
    s_valid = 1'b0;
    chk("prime_level", 16'(fifo_level), 16'd4);
    chk1("prime_not_playing", playing, 1'b0);
    chk("prime_state", 16'(state_dbg), 16'(PRIME));
    step();
    chk1("play_rise", playing, 1'b1);
    for (int c = 6; c <= 25; c++) begin
      step();
      chk1($sformatf("strobe_c%0d", c), pcm_strobe, ((c - 5) % 4) == 0);
      chk1($sformatf("underrun_c%0d", c), underrun, c == 25);
      if (c == 25) begin
        chk("ur_pcm", pcm_out, 16'h0000);
        chk("ur_state", 16'(state_dbg), 16'(PRIME));
        chk1("ur_playing", playing, 1'b0);
      end else if (((c - 5) % 4) == 0) begin
        exp_v = exp_q.pop_front();
        chk($sformatf("play_pcm_c%0d", c), pcm_out, exp_v);
      end
    end
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
    chk("ur_cnt", underrun_cnt, 16'd1);
`endif

    // Volume-shift vector table.
    for (int v = 0; v < 8; v++) begin
      enable = 1'b0; s_valid = 1'b0;
      step();
      chk($sformatf("vec%0d_flush_level", v), 16'(fifo_level), 16'd0);
      vol_shift = vecs[v].sh; sample_div = 16'd3;
      enable = 1'b1; s_valid = 1'b1; s_data = vecs[v].din;
      repeat (4) step();
      s_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        step();
        if (pcm_strobe) seen = 1'b1;
      end
      chk1($sformatf("vec%0d_strobe_seen", v), seen, 1'b1);
      chk($sformatf("vec%0d_pcm", v), pcm_out, vecs[v].want);
    end
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
    chk("vec_ur_cnt_kept", underrun_cnt, 16'd1);
`endif

    // Backpressure: fill with no ticks, then shorten the divider and stream through a full FIFO.
    enable = 1'b0; s_valid = 1'b0; vol_shift = 2'd0;
    step();
    exp_q.delete();
    sample_div = 16'd1000; enable = 1'b1; s_valid = 1'b1; s_data = 16'h0100;
    sb_on = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      s_data = 16'h0100 + 16'(k);
      chk($sformatf("fill_level_k%0d", k), 16'(fifo_level), 16'((k < 8) ? k : 8));
      chk1($sformatf("fill_s_ready_k%0d", k), s_ready, k < 8);
    end
    sample_div = 16'd10;
    for (int k = 0; k < 40; k++) begin
      step();
      s_data = 16'h0200 + 16'(k);
    end
    s_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || fifo_level != 4'd0) && guard < 300) begin
      step();
      guard++;
    end
    chk("sb_left", 16'(exp_q.size()), 16'd0);
    chk("drain_level", 16'(fifo_level), 16'd0);
    sb_on = 1'b0;
    exp_q.delete();

    // Stop mid-PLAY with level 5.
    enable = 1'b0;
    step();
    enable = 1'b1; sample_div = 16'd2; s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = 16'h2000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    step();
    step();
    chk("stop_pre_level", 16'(fifo_level), 16'd5);
    chk("stop_pre_pcm", pcm_out, 16'h2001);
    chk1("stop_pre_strobe", pcm_strobe, 1'b1);
    enable = 1'b0;
    #1;
    chk1("stop_s_ready", s_ready, 1'b0);
    step();
    chk("stop_level", 16'(fifo_level), 16'd0);
    chk("stop_pcm", pcm_out, 16'h0000);
    chk1("stop_no_strobe", pcm_strobe, 1'b0);
    chk("stop_state", 16'(state_dbg), 16'(IDLE));
    chk1("stop_s_ready_after", s_ready, 1'b0);

    // Asynchronous reset in PLAY right after a strobe, then a single sample must not play.
    enable = 1'b1; sample_div = 16'd3; s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = 16'h3000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (pcm_strobe) seen = 1'b1;
    end
    chk1("arst_pre_strobe", seen, 1'b1);
    chk1("arst_pre_playing", playing, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_strobe", pcm_strobe, 1'b0);
    chk("arst_pcm", pcm_out, 16'h0000);
    chk("arst_level", 16'(fifo_level), 16'd0);
    chk1("arst_playing", playing, 1'b0);
    chk("arst_state", 16'(state_dbg), 16'(IDLE));
    chk1("arst_s_ready", s_ready, 1'b0);
    chk1("arst_underrun", underrun, 1'b0);
`ifdef AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN
    chk("arst_ur_cnt", underrun_cnt, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    sample_div = 16'd0; s_valid = 1'b1; s_data = 16'h4000;
    step();
    s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk1($sformatf("replay_not_playing_c%0d", c), playing, 1'b0);
      chk1($sformatf("replay_no_strobe_c%0d", c), pcm_strobe, 1'b0);
    end
    chk("replay_state", 16'(state_dbg), 16'(PRIME));
    chk("replay_level", 16'(fifo_level), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/audio_stream_ctrl.md
AUDIO_STREAM_CTRL -- requirements
Module: audio_stream_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: sample FIFO depth; power of two, minimum 4.
REQ-002 Parameter DIV_W, default 16: width of the sample-rate divider.
REQ-003 Port clk, input, 1: the single clock; every flop is clocked on its rising edge.
REQ-004 Port rst, input, 1: reset; asynchronous, active-high.
REQ-005 Port enable, input, 1: 1 = run the stream; 0 = stop and flush.
REQ-006 Port sample_div, input, DIV_W: one sample tick every sample_div+1 clk cycles.
REQ-007 Port vol_shift, input, 2: arithmetic right shift (0-3) applied to each sample.
REQ-008 Port s_valid, input, 1: producer has a sample.
REQ-009 Port s_data, input, 16: signed PCM sample.
REQ-010 Port s_ready, output, 1: block accepts a sample.
REQ-011 Port pcm_out, output, 16: signed PCM to the 1-bit DAC; held between ticks.
REQ-012 Port pcm_strobe, output, 1: one-cycle pulse when pcm_out updates.
REQ-013 Port underrun, output, 1: one-cycle pulse when a tick finds the FIFO empty.
REQ-014 Port fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-015 Port playing, output, 1: high while in PLAY.

Function
REQ-016 A sample transfers on any cycle where s_valid && s_ready; s_ready = !full && enable.
REQ-017 The FSM has three states, IDLE, PRIME and PLAY, with these transitions: IDLE->PRIME when enable=1; PRIME->PLAY when fifo_level >= FIFO_DEPTH/2; PLAY->PRIME on underrun; any state->IDLE when enable=0.
REQ-018 The divider counter runs only in PLAY; it is held at 0 in IDLE and PRIME.
REQ-019 In PLAY, a tick fires on the cycle where the counter equals sample_div; on that cycle the counter returns to 0.
REQ-020 With sample_div=0, a tick fires every cycle.
REQ-021 A new sample_div value takes effect at the next counter comparison, with no glitch filtering.
REQ-022 On a tick with a non-empty FIFO, the block pops one sample; on the next cycle pcm_out = popped sample >>> vol_shift (sign-extended) and pcm_strobe = 1.
REQ-023 vol_shift is sampled on the tick cycle.
REQ-024 On a tick with an empty FIFO, the next cycle gives pcm_out = 0, pcm_strobe = 1 and underrun = 1, and the FSM enters PRIME.
REQ-025 When the FIFO is full, a push is refused (s_ready = 0) even if a pop occurs on the same cycle.
REQ-026 A push and a pop on the same cycle leave fifo_level unchanged.
REQ-027 On entry to IDLE, the FIFO flushes (level = 0) and pcm_out becomes 0 on the next cycle, with no strobe.
REQ-028 In PRIME, pcm_out holds its last value.

Reset
REQ-029 While rst is high, all of the following hold: state = IDLE, FIFO empty, divider = 0, pcm_out = 0, pcm_strobe = 0, underrun = 0, playing = 0, s_ready = 0.
REQ-030 An assertion of rst during PLAY aborts immediately; the first sample after release again requires a full prime.
REQ-031 FIFO storage needs no reset; only the pointers and the level are reset.

Configuration
REQ-032 The macro AUDIO_STREAM_CTRL_UNDERRUN_CNT_EN, when defined, adds output underrun_cnt[15:0].
REQ-033 underrun_cnt increments on each underrun pulse and saturates at 16'hFFFF.
REQ-034 underrun_cnt is cleared by rst only; it is not cleared by enable=0.
REQ-035 When the macro is undefined, the port and the counter are absent and all other behaviour is identical.

Structure
REQ-036 Package audio_ctrl_pkg holds PCM_W=16 and the state enum asc_state_t {IDLE, PRIME, PLAY}.
REQ-037 The FIFO is sub-module asc_fifo (synchronous, single clock, with a level output and a flush input).
REQ-038 The FSM, divider and volume shift live in the top module.

Verification
REQ-039 FIFO_DEPTH=8, sample_div=3: push 4 samples -> playing rises the cycle after level reaches 4; pcm_strobe pulses every 4 cycles.
REQ-040 Push 16'h8000 with vol_shift=2 -> pcm_out=16'hE000; push 16'h7FFF with vol_shift=3 -> pcm_out=16'h0FFF.
REQ-041 Stop pushing in PLAY -> after the last sample, the next tick gives pcm_out=0, underrun=1 and state PRIME; underrun_cnt=1 with the macro defined.
REQ-042 Hold s_valid=1 with no ticks -> s_ready drops when level=8, and no sample is lost or duplicated (scoreboard check).
REQ-043 Deassert enable mid-PLAY with level=5 -> level=0 and pcm_out=0 the next cycle, and s_ready=0.
REQ-044 Assert rst asynchronously between clock edges in PLAY -> outputs go to reset values without waiting for a clk edge; replay requires a prime.
